// File: rtl/adc_uart_frame_seq_pkg.sv
// ============================================================================
// Module      : adc_uart_pkg
// Description : Shared types and constants for the ADC-to-UART frame
//               sequencer: FSM state encoding, ASCII constants, frame-length
//               helper and a nibble-to-ASCII helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adc_uart_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    LATCH   = 3'd2,
    CONV    = 3'd3,
    EMIT    = 3'd4,
    WAIT_HI = 3'd5,
    WAIT_LO = 3'd6,
    NEXT    = 3'd7
  } state_t;

  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] ZERO  = 8'h30;
  localparam logic [7:0] HEX_A = 8'h41;

  // Bytes per frame: two channels, each `digits` characters plus CR LF.
  function automatic int frame_len(input int digits);
    return 2 * (digits + 2);
  endfunction

  // Decimal digits never exceed 9, so one mapping serves both BCD and hex.
  function automatic logic [7:0] nib_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return ZERO + {4'd0, nib};
    return HEX_A + {4'd0, nib - 4'd10};
  endfunction

endpackage

`default_nettype wire

// File: rtl/adc_uart_frame_seq_if.sv
// ============================================================================
// Module      : adc_uart_frame_seq_if
// Description : FIFO-read and UART-write handshake bundle for the sequencer.
//   fifo_empty  FIFO empty flag            (slave -> master)
//   fifo_rd_en  one-cycle pop strobe       (master -> slave)
//   fifo_dout   FIFO word, valid cycle after fifo_rd_en (slave -> master)
//   tx_data     byte to transmit           (master -> slave)
//   tx_wr       one-cycle write strobe     (master -> slave)
//   tx_busy     UART core busy flag        (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface adc_uart_frame_seq_if #(
  parameter int SAMPLE_W = 8
);
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [2*SAMPLE_W-1:0] fifo_dout;
  logic [7:0]            tx_data;
  logic                  tx_wr;
  logic                  tx_busy;

  modport master (
    input  fifo_empty, fifo_dout, tx_busy,
    output fifo_rd_en, tx_data, tx_wr
  );

  modport slave (
    output fifo_empty, fifo_dout, tx_busy,
    input  fifo_rd_en, tx_data, tx_wr
  );
endinterface

`default_nettype wire

// File: rtl/adc_uart_frame_seq_bin2bcd.sv
// ============================================================================
// Module      : bin2bcd_seq
// Description : Iterative shift-add-3 (double-dabble) binary to BCD
//               converter. A start pulse loads the operand; the result is
//               complete after exactly SAMPLE_W further cycles and held
//               until the next start.
//   clk, rst_n  clock, asynchronous active-low reset
//   start       load operand and begin conversion
//   bin         binary operand (sampled on start)
//   busy        conversion in progress
//   last        final shift step happens this cycle
//   bcd         DIGITS packed BCD digits, MS digit in the top nibble
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin2bcd_seq #(
  parameter int SAMPLE_W = 8,
  parameter int DIGITS   = 4
) (
  input  wire                  clk,
  input  wire                  rst_n,
  input  wire                  start,
  input  wire [SAMPLE_W-1:0]   bin,
  output logic                 busy,
  output logic                 last,
  output logic [4*DIGITS-1:0]  bcd
);

  localparam int CNT_W = $clog2(SAMPLE_W + 1);

  logic [SAMPLE_W-1:0] shreg;
  logic [CNT_W-1:0]    cnt;
  logic [4*DIGITS-1:0] adj;

  // Every digit of 5 or more gets +3 before the shift so it carries
  // correctly into the next decade after doubling.
  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    assign adj[4*d +: 4] = (bcd[4*d +: 4] >= 4'd5) ? bcd[4*d +: 4] + 4'd3
                                                    : bcd[4*d +: 4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      bcd   <= '0;
      cnt   <= '0;
    end else if (start) begin
      shreg <= bin;
      bcd   <= '0;
      cnt   <= CNT_W'(SAMPLE_W);
    end else if (cnt != '0) begin
      {bcd, shreg} <= {adj, shreg} << 1;
      cnt          <= cnt - CNT_W'(1);
    end
  end

  assign busy = (cnt != '0);
  assign last = (cnt == CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/adc_uart_frame_seq.sv
// ============================================================================
// Module      : adc_uart_frame_seq
// Description : Pops 2-channel sample words from the ADC FIFO, renders each
//               channel as fixed-width ASCII (decimal by default, uppercase
//               hex when HEX_FMT_EN is defined) followed by CR LF, and streams
//               the bytes to a UART core via a write/busy handshake.
//   clk, rst_n  clock, asynchronous active-low reset
//   start       run request, sampled only while idle
//   bus         adc_uart_frame_seq_if.master (FIFO pop + UART write)
//   run         high while a run is in progress
//   done        one-cycle pulse at run completion
//   err         sticky UART acknowledge timeout
//   sample_cnt  samples sent in current/last run, saturating
// Build macro : HEX_FMT_EN - hex rendering, no BCD conversion phase.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_uart_frame_seq
  import adc_uart_pkg::*;
#(
  parameter int SAMPLE_W    = 8,
  parameter int DIGITS      = 4,
  parameter int FRAME_MAX   = 0,
  parameter int ACK_TIMEOUT = 16
) (
  input  wire                   clk,
  input  wire                   rst_n,
  input  wire                   start,
  adc_uart_frame_seq_if.master  bus,
  output logic                  run,
  output logic                  done,
  output logic                  err,
  output logic [15:0]           sample_cnt
);

`ifdef HEX_FMT_EN
  localparam int ND = (SAMPLE_W + 3) / 4;
`else
  localparam int ND = DIGITS;
`endif
  localparam int VEC_W     = 4 * ND;
  localparam int CH_LEN    = ND + 2;
  localparam int FRAME_LEN = frame_len(ND);
  localparam int IDX_W     = $clog2(FRAME_LEN);
  localparam int TO_W      = $clog2(ACK_TIMEOUT + 1);

  state_t           state, state_nx;
  logic [IDX_W-1:0] byte_idx, byte_idx_nx;
  logic [TO_W-1:0]  tout, tout_nx;
  logic [15:0]      cnt_nx;
  logic             err_nx, done_nx;
  logic [VEC_W-1:0] dig_lo, dig_hi;
  logic             conv_fin;

`ifdef HEX_FMT_EN
  logic [2*SAMPLE_W-1:0] hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              hold <= '0;
    else if (state == LATCH) hold <= bus.fifo_dout;
  end

  assign dig_lo   = VEC_W'(hold[SAMPLE_W-1:0]);
  assign dig_hi   = VEC_W'(hold[2*SAMPLE_W-1:SAMPLE_W]);
  assign conv_fin = 1'b0;
`else
  logic busy_lo, busy_hi, last_lo, last_hi;

  // Converters load straight from the FIFO output in LATCH, so their shift
  // registers act as the holding register for the frame.
  bin2bcd_seq #(.SAMPLE_W(SAMPLE_W), .DIGITS(DIGITS)) u_conv_lo (
    .clk   (clk),
    .rst_n (rst_n),
    .start (state == LATCH),
    .bin   (bus.fifo_dout[SAMPLE_W-1:0]),
    .busy  (busy_lo),
    .last  (last_lo),
    .bcd   (dig_lo)
  );

  bin2bcd_seq #(.SAMPLE_W(SAMPLE_W), .DIGITS(DIGITS)) u_conv_hi (
    .clk   (clk),
    .rst_n (rst_n),
    .start (state == LATCH),
    .bin   (bus.fifo_dout[2*SAMPLE_W-1:SAMPLE_W]),
    .busy  (busy_hi),
    .last  (last_hi),
    .bcd   (dig_hi)
  );

  assign conv_fin = busy_lo & busy_hi & last_lo & last_hi;
`endif

  // Byte selection: index within the channel picks a digit, CR or LF.
  logic             hi_sel;
  logic [IDX_W-1:0] pos;
  logic [VEC_W-1:0] chan;
  logic [3:0]       nib;
  logic [7:0]       ch_byte;

  always_comb begin
    hi_sel = (byte_idx >= IDX_W'(CH_LEN));
    pos    = hi_sel ? byte_idx - IDX_W'(CH_LEN) : byte_idx;
    chan   = hi_sel ? dig_hi : dig_lo;
    nib    = '0;
    for (int d = 0; d < ND; d++) begin
      if (pos == IDX_W'(d)) nib = chan[4*(ND-1-d) +: 4];
    end
    if (pos < IDX_W'(ND))       ch_byte = nib_to_ascii(nib);
    else if (pos == IDX_W'(ND)) ch_byte = CR;
    else                        ch_byte = LF;
  end

  // tx_data is only meaningful during the byte handshake; zero otherwise.
  assign bus.tx_data = (state == EMIT || state == WAIT_HI || state == WAIT_LO)
                       ? ch_byte : 8'h00;
  assign run = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      byte_idx   <= '0;
      tout       <= '0;
      sample_cnt <= '0;
      err        <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nx;
      byte_idx   <= byte_idx_nx;
      tout       <= tout_nx;
      sample_cnt <= cnt_nx;
      err        <= err_nx;
      done       <= done_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    byte_idx_nx    = byte_idx;
    tout_nx        = tout;
    cnt_nx         = sample_cnt;
    err_nx         = err;
    done_nx        = 1'b0;
    bus.fifo_rd_en = 1'b0;
    bus.tx_wr      = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          if (!bus.fifo_empty) begin
            state_nx = RD;
            cnt_nx   = '0;
            err_nx   = 1'b0;
          end else begin
            done_nx  = 1'b1;
          end
        end
      end
      RD: begin
        bus.fifo_rd_en = 1'b1;
        state_nx       = LATCH;
      end
      LATCH: begin
        byte_idx_nx = '0;
`ifdef HEX_FMT_EN
        state_nx    = EMIT;
`else
        state_nx    = CONV;
`endif
      end
      CONV: begin
        if (conv_fin) state_nx = EMIT;
      end
      EMIT: begin
        if (!bus.tx_busy) begin
          bus.tx_wr = 1'b1;
          // The strobe cycle counts toward the acknowledge window.
          tout_nx   = TO_W'(1);
          state_nx  = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (bus.tx_busy) begin
          state_nx = WAIT_LO;
        end else if (tout >= TO_W'(ACK_TIMEOUT - 1)) begin
          err_nx   = 1'b1;
          done_nx  = 1'b1;
          state_nx = IDLE;
        end else begin
          tout_nx  = tout + TO_W'(1);
        end
      end
      WAIT_LO: begin
        if (!bus.tx_busy) begin
          if (byte_idx == IDX_W'(FRAME_LEN - 1)) begin
            state_nx = NEXT;
          end else begin
            byte_idx_nx = byte_idx + IDX_W'(1);
            state_nx    = EMIT;
          end
        end
      end
      NEXT: begin
        cnt_nx = (sample_cnt == 16'hFFFF) ? sample_cnt : sample_cnt + 16'd1;
        if ((FRAME_MAX != 0 && cnt_nx == 16'(FRAME_MAX)) || bus.fifo_empty) begin
          done_nx  = 1'b1;
          state_nx = IDLE;
        end else begin
          state_nx = RD;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: doc/adc_uart_frame_seq.md
Name: adc_uart_frame_seq

Overview:
Sequencer between the ADC sample FIFO and the byte-wide UART transmitter. On a start request it pops 16-bit words from the FIFO and converts both 8-bit channels to fixed-width ASCII decimal. It streams each frame to the UART byte core through a write/busy handshake, and stops on FIFO empty or after a configured sample count. It replaces free-running, busy-edge-clocked array indexing with a single-clock FSM.

Parameters:
SAMPLE_W, 8, bits per channel; the FIFO word is 2*SAMPLE_W wide.
DIGITS, 4, decimal digits per channel, leading zeros printed; must be >= ceil(log10(2^SAMPLE_W)).
FRAME_MAX, 0, samples per run; 0 means run until the FIFO is empty.
ACK_TIMEOUT, 16, cycles allowed for tx_busy to rise after tx_wr.

Ports:
clk  in  1  system clock.
rst_n  in  1  reset, asynchronous, active-low.
start  in  1  synchronous, debounced run request; sampled only in IDLE.
fifo_empty  in  1  FIFO empty flag, same clock domain.
fifo_rd_en  out  1  one-cycle pop strobe.
fifo_dout  in  2*SAMPLE_W  FIFO data, valid the cycle after fifo_rd_en.
tx_data  out  8  byte to transmit, held stable from tx_wr until tx_busy falls.
tx_wr  out  1  one-cycle write strobe to the UART core.
tx_busy  in  1  UART core busy flag.
run  out  1  high from start acceptance to return to IDLE.
done  out  1  one-cycle pulse on run completion.
err  out  1  sticky ack-timeout flag; cleared by reset or by the next accepted start.
sample_cnt  out  16  samples sent in the current or last run; saturates at 0xFFFF.

Behaviour:
- Reset values: all outputs 0; tx_data = 0x00; FSM state IDLE.
- IDLE:
  - start=1 and fifo_empty=0: go to RD; clear sample_cnt and err; assert run.
  - start=1 and fifo_empty=1: pulse done on the next cycle; no pop; run stays 0.
- RD: fifo_rd_en=1 for exactly one cycle, then go to LATCH.
- LATCH: capture fifo_dout into a holding register, then go to CONV.
- CONV: iterative double-dabble, both channels in parallel, exactly SAMPLE_W cycles, then go to EMIT.
- Frame byte order:
  - lo[SAMPLE_W-1:0] as DIGITS characters, MS digit first, then 0x0D, 0x0A;
  - then hi[2*SAMPLE_W-1:SAMPLE_W] the same way.
  - Frame length is 2*(DIGITS+2) = 12 bytes by default.
  - Digit character = 0x30 + BCD nibble.
- EMIT: wait while tx_busy=1. When tx_busy=0, drive tx_data, pulse tx_wr for one cycle, go to WAIT_HI.
- WAIT_HI:
  - tx_busy=1: go to WAIT_LO.
  - ACK_TIMEOUT cycles elapse without tx_busy=1: set err, pulse done, go to IDLE.
- WAIT_LO: wait for tx_busy=0. Then, if bytes remain, go to EMIT with the next byte; otherwise go to NEXT.
- NEXT:
  - Increment sample_cnt.
  - If FRAME_MAX!=0 and sample_cnt reaches FRAME_MAX, or fifo_empty=1: pulse done, deassert run, go to IDLE.
  - Otherwise go to RD.
- Latency: start accepted at cycle 0 → fifo_rd_en at cycle 1 → capture at cycle 2 → CONV cycles 3..10 → first tx_wr at cycle 11 (SAMPLE_W=8, tx_busy=0).
- start asserted while run=1 is ignored. fifo_empty is only examined in IDLE and NEXT, so no pop ever occurs while the FIFO is empty.
- A frame is never truncated: once popped, all its bytes are emitted unless an ack timeout occurs.
- Reset mid-frame: immediate return to IDLE; remaining bytes are discarded; no done pulse.

Optional Feature:
HEX_FMT_EN
- Defined: each channel is sent as ceil(SAMPLE_W/4) uppercase hex characters ('0'-'9', 'A'-'F') plus CR LF, giving 8 bytes for SAMPLE_W=8. CONV is skipped; LATCH goes directly to EMIT, so the first tx_wr is at cycle 3.
- Undefined: decimal behaviour as above.

Decomposition:
- Package adc_uart_pkg: FSM state enum (IDLE, RD, LATCH, CONV, EMIT, WAIT_HI, WAIT_LO, NEXT); ASCII constants CR=8'h0D, LF=8'h0A, ZERO=8'h30, HEX_A=8'h41; a frame-length helper function.
- Sub-module bin2bcd_seq: start/busy handshake, SAMPLE_W-cycle shift-add-3 converter, instantiated once per channel.

Test Plan:
- FIFO holds 0x0AFF; start pulse; tx_busy model 10 cycles/byte → bytes "0255\r\n0010\r\n", one fifo_rd_en, done after the last byte, sample_cnt=1.
- fifo_empty=1 at start → no fifo_rd_en, no tx_wr, done one cycle later, run never high.
- FRAME_MAX=3, FIFO holds 5 words → exactly 3 pops and 36 bytes; 2 words remain; sample_cnt=3.
- tx_busy held 0 after a tx_wr → err=1 and done pulse 16 cycles after tx_wr; the next accepted start clears err.
- rst_n low during byte 5 of a frame → all outputs return to 0 asynchronously; after release, the next start begins a fresh frame from byte 0.
- HEX_FMT_EN defined, FIFO holds 0x3CA5 → bytes "A5\r\n3C\r\n", first tx_wr at cycle 3.
